// File: rtl/spart_pkg.sv
// SPART shared definitions: FSM states and framing constants,
// common to the receive and transmit paths.
package spart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

endpackage

// File: rtl/spart_baud_gen.sv
// SPART baud generator: free-running down-counter that pulses
// tick_o once every divisor_i+1 clocks.
module spart_baud_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] divisor_i,
  output logic        tick_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign tick_o = (cnt_q == 16'd0);

  // Reload on the tick edge so a new divisor applies next period
  assign cnt_d = tick_o ? divisor_i : cnt_q - 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 8N1 deserializer with 16x oversampling and a
// one-entry receive buffer with framing/overrun status.
module spart_rx
  import spart_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic [15:0] divisor,
  input  logic        rd_ack,
  output logic [7:0]  rx_data,
  output logic        rda,
  output logic        framing_err,
  output logic        overrun
);

  localparam logic [3:0] MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] WRAP = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST = 3'(DATA_BITS - 1);

  logic       tick;
  logic [1:0] sync_q;
  logic       rxs;

  state_e     state_q, state_d;
  logic [3:0] scnt_q, scnt_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] sh_q, sh_d;
  logic       commit;

  logic [7:0] rx_data_q, rx_data_d;
  logic       rda_q, rda_d;
  logic       fe_q, fe_d;
  logic       ov_q, ov_d;

  spart_baud_gen u_baud (
    .clk       (clk),
    .rst       (rst),
    .divisor_i (divisor),
    .tick_o    (tick)
  );

  assign rxs = sync_q[1];

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          scnt_d  = 4'd0;
        end
      end
      START: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == MID) begin
            scnt_d  = 4'd0;
            bidx_d  = 3'd0;
            state_d = rxs ? IDLE : DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == WRAP) begin
            sh_d   = {rxs, sh_q[7:1]};
            bidx_d = bidx_q + 3'd1;
            if (bidx_q == LAST) begin
              state_d = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          scnt_d = scnt_q + 4'd1;
          if (scnt_q == WRAP) begin
            commit  = 1'b1;
            state_d = rxs ? IDLE : BREAK;
          end
        end
      end
      BREAK: begin
        // Hold off start detection until the line recovers
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_data_d = rx_data_q;
    rda_d     = rda_q;
    fe_d      = fe_q;
    ov_d      = ov_q;
    if (commit) begin
      rx_data_d = sh_q;
      rda_d     = 1'b1;
      fe_d      = ~rxs;
      ov_d      = rda_q & ~rd_ack;
    end else if (rd_ack) begin
      rda_d = 1'b0;
      fe_d  = 1'b0;
      ov_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      scnt_q    <= 4'd0;
      bidx_q    <= 3'd0;
      sh_q      <= 8'h00;
      rx_data_q <= 8'h00;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rxd};
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bidx_q    <= bidx_d;
      sh_q      <= sh_d;
      rx_data_q <= rx_data_d;
      rda_q     <= rda_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rda         = rda_q;
  assign framing_err = fe_q;
  assign overrun     = ov_q;

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: table of frames plus
// hand-written glitch, break, commit/ack and reset sequences.
module tb_spart_rx;

  localparam int BIT = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [15:0] divisor = 16'd1;
  logic        rd_ack = 1'b0;
  logic [7:0]  rx_data;
  logic        rda;
  logic        framing_err;
  logic        overrun;

  int  total = 0;
  int  bad = 0;
  time t_start = 0;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       ov;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       ack;
    exp_t       e;
  } vec_t;

  exp_t sbq[$];

  spart_rx dut (
    .clk         (clk),
    .rst         (rst),
    .rxd         (rxd),
    .divisor     (divisor),
    .rd_ack      (rd_ack),
    .rx_data     (rx_data),
    .rda         (rda),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    clks(1);
    rd_ack = 1'b0;
  endtask

  task automatic send(input logic [7:0] d,
                      input logic stop,
                      input int stop_clks);
    rxd = 1'b0;
    t_start = $time;
    clks(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      clks(BIT);
    end
    rxd = stop;
    clks(stop_clks);
    rxd = 1'b1;
    clks(16);
  endtask

  task automatic watch(output int lat);
    int n = 0;
    clks(1);
    while (!rda && n < 400) begin
      clks(1);
      n++;
    end
    lat = int'(($time - t_start) / 10);
  endtask

  task automatic sb_check(input string nm);
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s act=empty exp=entry", nm);
    end else begin
      e = sbq.pop_front();
      chk({nm, ".rda"}, 32'(rda), 32'd1);
      chk({nm, ".data"}, 32'(rx_data), 32'(e.d));
      chk({nm, ".fe"}, 32'(framing_err), 32'(e.fe));
      chk({nm, ".ov"}, 32'(overrun), 32'(e.ov));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   lat;
    int   lcal;
    time  tcal;

    tbl[0] = '{8'hA5, 1'b1, '{8'hA5, 1'b0, 1'b0}};
    tbl[1] = '{8'h00, 1'b1, '{8'h00, 1'b0, 1'b0}};
    tbl[2] = '{8'hFF, 1'b1, '{8'hFF, 1'b0, 1'b0}};
    tbl[3] = '{8'h81, 1'b1, '{8'h81, 1'b0, 1'b0}};
    tbl[4] = '{8'h01, 1'b1, '{8'h01, 1'b0, 1'b0}};
    tbl[5] = '{8'h02, 1'b0, '{8'h02, 1'b0, 1'b1}};

    clks(4);
    chk("rst.rda", 32'(rda), 32'd0);
    chk("rst.data", 32'(rx_data), 32'd0);
    chk("rst.fe", 32'(framing_err), 32'd0);
    chk("rst.ov", 32'(overrun), 32'd0);
    rst = 1'b0;
    clks(40);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].ack) ack();
      sbq.push_back(tbl[i].e);
      fork
        send(tbl[i].d, 1'b1, BIT);
        watch(lat);
      join
      if (i == 0) begin
        chk("lat.lo", 32'(lat >= 300), 32'd1);
        chk("lat.hi", 32'(lat <= 312), 32'd1);
      end
      sb_check($sformatf("tbl%0d", i));
    end

    ack();
    chk("ovclr.rda", 32'(rda), 32'd0);
    chk("ovclr.ov", 32'(overrun), 32'd0);
    chk("ovclr.fe", 32'(framing_err), 32'd0);
    chk("ovclr.data", 32'(rx_data), 32'h02);

    rxd = 1'b0;
    clks(6);
    rxd = 1'b1;
    clks(400);
    chk("glitch.rda", 32'(rda), 32'd0);
    sbq.push_back('{8'h3C, 1'b0, 1'b0});
    send(8'h3C, 1'b1, BIT);
    sb_check("glitch.next");

    ack();
    sbq.push_back('{8'h55, 1'b1, 1'b0});
    send(8'h55, 1'b0, 2 * BIT);
    sb_check("brk");
    ack();
    clks(400);
    chk("brk.nospur", 32'(rda), 32'd0);
    sbq.push_back('{8'h12, 1'b0, 1'b0});
    send(8'h12, 1'b1, BIT);
    sb_check("brk.next");

    ack();
    sbq.push_back('{8'h7E, 1'b0, 1'b0});
    fork
      send(8'h7E, 1'b1, BIT);
      watch(lcal);
    join
    tcal = t_start;
    sb_check("cal");
    while (((($time - tcal) / 10) % 2) != 0) clks(1);
    sbq.push_back('{8'h7E, 1'b0, 1'b0});
    fork
      send(8'h7E, 1'b1, BIT);
      begin
        clks(lcal - 1);
        rd_ack = 1'b1;
        clks(1);
        rd_ack = 1'b0;
      end
    join
    sb_check("ackcommit");

    rxd = 1'b0;
    clks(BIT);
    rxd = 1'b1;
    clks(2 * BIT);
    rxd = 1'b0;
    clks(2 * BIT);
    rst = 1'b1;
    clks(2);
    chk("midrst.rda", 32'(rda), 32'd0);
    chk("midrst.data", 32'(rx_data), 32'd0);
    chk("midrst.fe", 32'(framing_err), 32'd0);
    chk("midrst.ov", 32'(overrun), 32'd0);
    rxd = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(2 * BIT);
    chk("postrst.rda", 32'(rda), 32'd0);
    sbq.push_back('{8'hC3, 1'b0, 1'b0});
    send(8'hC3, 1'b1, BIT);
    sb_check("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spart_rx.md
# spart_rx

Receive half of the SPART serial port. Deserializes 8N1 asynchronous frames from the `rxd` pin using 16x oversampling from a programmable divisor, holds the completed byte in a one-entry buffer, and signals `rda` to the bus interface until the byte is read. It sits beside the SPART transmit path and shares its divisor registers and baud generator design.

## Interface
- `OVERSAMPLE`, default 16: samples per bit; fixed, not a supported override.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  serial input, idle high; asynchronous to `clk`.
- `divisor`  in  16  baud divisor {db_high, db_low}; one oversample tick every `divisor`+1 clocks.
- `rd_ack`  in  1  one-cycle strobe: bus read of the receive buffer (iocs & iorw & ioaddr==00).
- `rx_data`  out  8  last received byte; reset 8'h00.
- `rda`  out  1  receive data available; reset 0.
- `framing_err`  out  1  stop bit sampled low on the buffered byte; reset 0.
- `overrun`  out  1  a byte completed while `rda` was already 1; reset 0.

## Operation
- `rxd` passes through a 2-flop synchronizer (both flops reset to 1); the FSM uses only the synchronized value.
- Baud generator: 16-bit down-counter, reset to 0; emits `tick` when it reaches 0, reloading `divisor` on the same edge. Free-running, independent of the FSM. `divisor`=0 gives a tick every clock. A `divisor` change takes effect at the next reload.
- 4-bit tick counter `scnt`, 3-bit bit index `bidx`, 8-bit shift register.
- FSM states:
  - IDLE: synced `rxd`==0 -> START, `scnt`=0.
  - START: on tick `scnt`++; at `scnt`==7 tick (8th tick, mid-bit) sample: 0 -> DATA, `scnt`=0, `bidx`=0; 1 -> IDLE (glitch rejected, nothing reported).
  - DATA: on each tick `scnt`++; at wrap (16th tick) sample into shift register LSB-first; `bidx`==7 -> STOP.
  - STOP: at 16th tick sample stop bit, commit (below); sample 1 -> IDLE, sample 0 -> BREAK.
  - BREAK: wait for synced `rxd`==1, then IDLE. No new start detected while line stays low.
- Commit (single cycle): `rx_data` <= shift register, `rda` <= 1, `framing_err` <= (stop==0), `overrun` <= `rda` & ~`rd_ack`.
- `rd_ack` with no commit that cycle: `rda`, `framing_err`, `overrun` <= 0; `rx_data` held.
- `rd_ack` coincident with commit: commit wins; `rda` stays 1; `overrun` not set.
- Overrun: new byte overwrites `rx_data`; `overrun` stays 1 until `rd_ack`.
- `rd_ack` while `rda`==0: no effect.
- `rst` mid-frame: all state to reset values immediately; FSM to IDLE; partial byte discarded.

## Timing
- Pin-to-FSM latency: 2 clocks (synchronizer).
- Start-detection jitter: up to one tick (1/16 bit) because the baud generator is free-running.
- Bit period = 16*(`divisor`+1) clocks; data bit n sampled 8+16*(n+1) ticks after start detection; stop bit at 8+16*9 = 152 ticks.
- `rda`/`rx_data`/`framing_err`/`overrun` update on the clock edge after the stop-sample tick cycle (registered outputs, no combinational path from `rxd` or `rd_ack`).
- Back-to-back frames supported: from IDLE, a start edge immediately after stop sample is accepted.

## Structure
- Package `spart_pkg`: FSM state enum (IDLE, START, DATA, STOP, BREAK), constants `OVERSAMPLE`=16, `MID_SAMPLE`=7, `DATA_BITS`=8; shared with the transmit path.
- One sub-module: `spart_baud_gen` (divisor in, `tick` out), reused by the transmitter.

## Test plan
- `divisor`=1 (bit = 32 clk), send 8'hA5 stop=1 -> `rda` rises ~304 clk after start edge, `rx_data`=A5, `framing_err`=0, `overrun`=0.
- Low pulse of 3 ticks on idle line -> FSM returns to IDLE, `rda` stays 0, next frame 8'h3C received correctly.
- Frame 8'h55 with stop bit driven 0, line held low 2 bit times -> `rda`=1, `rx_data`=55, `framing_err`=1; no spurious second byte; next frame after line high received.
- Two frames 8'h01, 8'h02 without `rd_ack` -> `rx_data`=02, `overrun`=1; `rd_ack` -> `rda`, `overrun`, `framing_err` all 0.
- `rd_ack` asserted in the commit cycle of 8'h7E with `rda`=1 -> `rda`=1, `rx_data`=7E, `overrun`=0.
- `rst` asserted during bit 4 of a frame, released, then 8'hC3 sent -> outputs at reset values after `rst`, then `rx_data`=C3, `rda`=1.
